// File: rtl/write_back_commit_unit.sv
// Write-back / commit stage: result mux, gated register write, commit-trace FIFO,
// retired counter and ecall-driven halt. Optional WB_TRACE_MEM_EN carries memory-access info in the trace.
module write_back_commit_unit #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned NUM_SRC     = 5,
   parameter int unsigned TRACE_DEPTH = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                          i_clk,
   input  logic                          i_arst_n,
   input  logic                          i_valid,
   input  logic [$clog2(NUM_SRC)-1:0]    i_result_src,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
   input  logic [REG_ADDR_W-1:0]         i_rd_addr,
   input  logic                          i_reg_we,
   input  logic [ADDR_WIDTH-1:0]         i_pc,
   input  logic [INSTR_WIDTH-1:0]        i_instruction,
   input  logic                          i_ecall,
   input  logic [DATA_WIDTH-1:0]         i_a0,
`ifdef WB_TRACE_MEM_EN
   input  logic                          i_mem_access,
   input  logic                          i_mem_we,
   input  logic [ADDR_WIDTH-1:0]         i_mem_addr,
   input  logic [DATA_WIDTH-1:0]         i_mem_wdata,
   output logic                          o_trace_mem_access,
   output logic                          o_trace_mem_we,
   output logic [ADDR_WIDTH-1:0]         o_trace_mem_addr,
   output logic [DATA_WIDTH-1:0]         o_trace_mem_wdata,
`endif
   output logic                          o_stall,
   output logic [DATA_WIDTH-1:0]         o_result,
   output logic [REG_ADDR_W-1:0]         o_rd_addr,
   output logic                          o_reg_we,
   input  logic                          i_trace_ready,
   output logic                          o_trace_valid,
   output logic [ADDR_WIDTH-1:0]         o_trace_pc,
   output logic [INSTR_WIDTH-1:0]        o_trace_instr,
   output logic [DATA_WIDTH-1:0]         o_trace_rd_val,
   output logic [REG_ADDR_W-1:0]         o_trace_rd_addr,
   output logic                          o_trace_rd_we,
   output logic [CNT_W-1:0]              o_retired_cnt,
   output logic                          o_halt,
   output logic [7:0]                    o_exit_code
);

   localparam int unsigned SEL_W = $clog2(NUM_SRC);
   localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

   typedef struct packed {
`ifdef WB_TRACE_MEM_EN
      logic                   mem_access;
      logic                   mem_we;
      logic [ADDR_WIDTH-1:0]  mem_addr;
      logic [DATA_WIDTH-1:0]  mem_wdata;
`endif
      logic [ADDR_WIDTH-1:0]  pc;
      logic [INSTR_WIDTH-1:0] instr;
      logic [DATA_WIDTH-1:0]  rd_val;
      logic [REG_ADDR_W-1:0]  rd_addr;
      logic                   rd_we;
   } entry_t;

   state_e           state_q, state_d;
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       exit_q, exit_d;
   entry_t           mem_q [TRACE_DEPTH];
   entry_t           push_entry, head;
   logic             fifo_full, fifo_empty, accept, pop;

   // Only a0[7:0] is architecturally observed as the exit code.
   logic unused_a0_hi;
   assign unused_a0_hi = ^i_a0[DATA_WIDTH-1:8];

   always_comb begin
      o_result = '0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         if (i_result_src == SEL_W'(k)) o_result = i_src_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Full/empty come from registered pointers only, so a same-cycle pop never frees a slot early.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   // FSM: state register
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) state_q <= RUN;
      else           state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (accept && i_ecall) state_d = DRAIN;
         DRAIN:   if (fifo_empty)        state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_stall = fifo_full || (state_q != RUN);
      accept  = i_valid && (state_q == RUN) && !fifo_full;
      o_halt  = (state_q == HALT);
   end

   assign o_rd_addr     = i_rd_addr;
   assign o_reg_we      = accept && i_reg_we;
   assign o_trace_valid = !fifo_empty;
   assign pop           = o_trace_valid && i_trace_ready;

   always_comb begin
      push_entry         = '0;
      push_entry.pc      = i_pc;
      push_entry.instr   = i_instruction;
      push_entry.rd_val  = o_result;
      push_entry.rd_addr = i_rd_addr;
      push_entry.rd_we   = i_reg_we;
`ifdef WB_TRACE_MEM_EN
      push_entry.mem_access = i_mem_access;
      push_entry.mem_we     = i_mem_we;
      push_entry.mem_addr   = i_mem_addr;
      push_entry.mem_wdata  = i_mem_wdata;
`endif
   end

   always_comb begin
      wr_ptr_d = accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop    ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      cnt_d    = accept ? cnt_q + CNT_W'(1) : cnt_q;
      exit_d   = (accept && i_ecall) ? i_a0[7:0] : exit_q;
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         exit_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         exit_q   <= exit_d;
      end
   end

   // NOTE: trace storage has no reset; stale entries are masked by the head mux below.
   always_ff @(posedge i_clk) begin
      if (accept) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
   end

   assign head = o_trace_valid ? mem_q[rd_ptr_q[PTR_W-1:0]] : '0;

   assign o_trace_pc      = head.pc;
   assign o_trace_instr   = head.instr;
   assign o_trace_rd_val  = head.rd_val;
   assign o_trace_rd_addr = head.rd_addr;
   assign o_trace_rd_we   = head.rd_we;
`ifdef WB_TRACE_MEM_EN
   assign o_trace_mem_access = head.mem_access;
   assign o_trace_mem_we     = head.mem_we;
   assign o_trace_mem_addr   = head.mem_addr;
   assign o_trace_mem_wdata  = head.mem_wdata;
`endif

   assign o_retired_cnt = cnt_q;
   assign o_exit_code   = exit_q;

endmodule
